// File: rtl/gate_direction_decoder.sv
// Queue-gate front-end: synchronises and debounces two beam sensors, then
// decodes the traversal order into entry/exit strobes and a fault strobe.
module gate_direction_decoder #(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic sens_a,
  input  logic sens_b,
  output logic up_pulse,
  output logic down_pulse,
  output logic busy,
  output logic fault
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLR
  } state_t;

  // Bit 1 carries sensor A (outer), bit 0 sensor B (inner).
  logic [1:0] sync1, sync2, db, upd;
  logic [7:0] cnt [2];
  logic [TW-1:0] timer;
  state_t state, state_n;
  logic up_n, down_n, fault_n, timed, tmo;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      upd[i] = (sync2[i] != db[i]) && (cnt[i] == DEB_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= {sens_a, sens_b};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  assign timed = (state != IDLE) && (state != WAIT_CLR);
  assign tmo   = timed && (timer == TMO_LAST);

  always_comb begin
    state_n = state;
    up_n    = 1'b0;
    down_n  = 1'b0;
    fault_n = 1'b0;
    case (state)
      IDLE: case (db)
        2'b10:   state_n = IN1;
        2'b01:   state_n = OUT1;
        2'b11:   begin state_n = WAIT_CLR; fault_n = 1'b1; end
        default: state_n = IDLE;
      endcase
      IN1: case (db)
        2'b11:   state_n = IN2;
        2'b00:   state_n = IDLE;
        2'b01:   begin state_n = WAIT_CLR; fault_n = 1'b1; end
        default: state_n = IN1;
      endcase
      IN2: case (db)
        2'b01:   state_n = IN3;
        2'b10:   state_n = IN1;
        2'b00:   begin state_n = WAIT_CLR; fault_n = 1'b1; end
        default: state_n = IN2;
      endcase
      IN3: case (db)
        2'b00:   begin state_n = IDLE; up_n = 1'b1; end
        2'b11:   state_n = IN2;
        2'b10:   begin state_n = WAIT_CLR; fault_n = 1'b1; end
        default: state_n = IN3;
      endcase
      OUT1: case (db)
        2'b11:   state_n = OUT2;
        2'b00:   state_n = IDLE;
        2'b10:   begin state_n = WAIT_CLR; fault_n = 1'b1; end
        default: state_n = OUT1;
      endcase
      OUT2: case (db)
        2'b10:   state_n = OUT3;
        2'b01:   state_n = OUT1;
        2'b00:   begin state_n = WAIT_CLR; fault_n = 1'b1; end
        default: state_n = OUT2;
      endcase
      OUT3: case (db)
        2'b00:   begin state_n = IDLE; down_n = 1'b1; end
        2'b11:   state_n = OUT2;
        2'b01:   begin state_n = WAIT_CLR; fault_n = 1'b1; end
        default: state_n = OUT3;
      endcase
      WAIT_CLR: if (db == 2'b00) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    // Timeout only wins when the inputs would otherwise leave the state alone.
    if (tmo && (state_n == state)) begin
      state_n = WAIT_CLR;
      fault_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      up_pulse   <= up_n;
      down_pulse <= down_n;
      fault      <= fault_n;
      if (!timed || (state_n != state) || (upd != 2'b00)) begin
        timer <= '0;
      end else if (timer != TMO_MAX) begin
        timer <= timer + TW'(1);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_gate_direction_decoder.sv
// Self-checking bench: directed scenarios plus random sensor traffic, checked
// cycle by cycle against a displacement-based model of a gate traversal.
module tb_gate_direction_decoder;

  localparam int DEB = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic up_pulse, down_pulse, busy, fault;

  gate_direction_decoder #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: debounced value = delayed raw value that has held for DEB
  // samples; a traversal is a walk around 00-10-11-01, tracked as displacement d.
  logic [1:0] hist [256];
  int n, mode, d, last_move;
  logic [1:0] mdb;
  logic exp_up, exp_down, exp_fault;

  function automatic int pos(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_step();
    int pc, cp, delta, idx;
    logic ok;
    logic smp;
    if (!reset) begin
      n = 0; mdb = 2'b00; mode = 0; d = 0; last_move = 0;
      exp_up = 1'b0; exp_down = 1'b0; exp_fault = 1'b0;
      for (int i = 0; i < 256; i++) hist[i] = 2'b00;
      return;
    end
    n++;
    hist[n % 256] = {sens_a, sens_b};
    exp_up = 1'b0; exp_down = 1'b0; exp_fault = 1'b0;
    pc = pos(mdb);
    case (mode)
      0: begin
        if (pc == 1) begin mode = 1; d = 1; last_move = n; end
        else if (pc == 3) begin mode = 1; d = -1; last_move = n; end
        else if (pc == 2) begin mode = 2; exp_fault = 1'b1; end
      end
      1: begin
        cp = (d + 4) % 4;
        if (pc == cp) begin
          if (n - last_move == TMO) begin mode = 2; exp_fault = 1'b1; end
        end else begin
          delta = (pc - cp + 4) % 4;
          if (delta == 2) begin
            mode = 2; exp_fault = 1'b1;
          end else begin
            d = d + ((delta == 1) ? 1 : -1);
            last_move = n;
            if (d == 4) begin mode = 0; exp_up = 1'b1; end
            else if (d == -4) begin mode = 0; exp_down = 1'b1; end
            else if (d == 0) mode = 0;
          end
        end
      end
      default: if (pc == 0) mode = 0;
    endcase
    for (int b = 0; b < 2; b++) begin
      ok = 1'b1;
      for (int k = 2; k <= DEB + 1; k++) begin
        idx = n - k;
        smp = (idx >= 1) ? hist[idx % 256][b] : 1'b0;
        if (smp == mdb[b]) ok = 1'b0;
      end
      if (ok) mdb[b] = ~mdb[b];
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  int n_up = 0, n_down = 0, n_fault = 0, n_busy = 0;
  int cyc = 0, busy_t = 0, fault_t = 0;
  logic busy_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    check("up", up_pulse, exp_up);
    check("down", down_pulse, exp_down);
    check("fault", fault, exp_fault);
    check("busy", busy, (mode != 0));
    check("onehot", (32'(up_pulse) + 32'(down_pulse) + 32'(fault)) > 1, 0);
    if (up_pulse === 1'b1) n_up++;
    if (down_pulse === 1'b1) n_down++;
    if (fault === 1'b1) begin n_fault++; fault_t = cyc; end
    if (busy === 1'b1) n_busy++;
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_t = cyc;
    busy_prev = busy;
  end

  task automatic hold(input logic [1:0] p, input int c);
    {sens_a, sens_b} = p;
    repeat (c) @(negedge clk);
  endtask

  task automatic entry_seq();
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 15);
  endtask

  int u0, d0, f0, b0;

  task automatic snap();
    u0 = n_up; d0 = n_down; f0 = n_fault; b0 = n_busy;
  endtask

  initial begin
    #3;
    check("rst_up", up_pulse, 0);
    check("rst_down", down_pulse, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    hold(2'b00, 5);

    snap(); entry_seq();
    check("entry_up", n_up - u0, 1);
    check("entry_down", n_down - d0, 0);
    check("entry_fault", n_fault - f0, 0);
    check("entry_idle", busy, 0);

    snap();
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 15);
    check("exit_down", n_down - d0, 1);
    check("exit_up", n_up - u0, 0);

    snap();
    for (int i = 0; i < 3; i++) entry_seq();
    check("entry3_up", n_up - u0, 3);

    snap();
    hold(2'b10, 10); hold(2'b00, 15);
    check("balk_busy_seen", (n_busy - b0) > 0, 1);
    check("balk_pulses", (n_up - u0) + (n_down - d0) + (n_fault - f0), 0);
    check("balk_idle", busy, 0);

    snap();
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b10, 10);
    hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 15);
    check("backtrack_up", n_up - u0, 1);
    check("backtrack_fault", n_fault - f0, 0);

    snap();
    hold(2'b10, 2); hold(2'b00, 10); hold(2'b10, 3); hold(2'b00, 10);
    check("glitch_busy", n_busy - b0, 0);
    check("glitch_pulses", (n_up - u0) + (n_down - d0) + (n_fault - f0), 0);

    snap();
    hold(2'b10, 100); hold(2'b00, 20);
    check("tmo_fault", n_fault - f0, 1);
    check("tmo_delay", fault_t - busy_t, TMO);
    check("tmo_up", n_up - u0, 0);
    check("tmo_idle", busy, 0);

    snap();
    hold(2'b11, 20); hold(2'b00, 20);
    check("illegal_fault", n_fault - f0, 1);
    check("illegal_count", (n_up - u0) + (n_down - d0), 0);

    snap();
    hold(2'b10, 10); hold(2'b11, 10);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_up", up_pulse, 0);
    check("arst_down", down_pulse, 0);
    check("arst_fault", fault, 0);
    {sens_a, sens_b} = 2'b00;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    hold(2'b00, 15);
    check("post_rst_idle", busy, 0);
    check("post_rst_pulses", (n_up - u0) + (n_down - d0), 0);
    snap(); entry_seq();
    check("post_rst_entry", n_up - u0, 1);

    for (int s = 0; s < 250; s++) begin
      logic [1:0] p;
      int len;
      p = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 90))
                                         : int'($urandom_range(1, 14));
      hold(p, len);
    end
    hold(2'b00, 40);
    check("rand_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
